hamming_scrub_ctrl: RTL and testbench

- Background memory scrubber for (16,11) SECDED Hamming-protected storage.
- Walks every address, reads the codeword, and runs the syndrome/overall-parity check.
- Writes back the repaired codeword when a single-bit error is found; counts and logs uncorrectable errors.
- Shares the memory port through an external arbiter (mem_gnt) and sequences the decode datapath; sits between the system arbiter and the protected RAM.

---
 rtl/hamming_pkg.sv | 29 ++
 rtl/hamming_syndrome_chk.sv | 34 +++
 rtl/hamming_scrub_ctrl.sv | 144 ++++++++++++++
 tb/tb_hamming_scrub_ctrl.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared types and constants for the (16,11) SECDED scrubber and decoder.
package hamming_pkg;

  localparam int CW_W   = 16;
  localparam int DATA_W = 11;

  // Codeword positions (1-based) that carry parity.
  localparam int P1  = 1;
  localparam int P2  = 2;
  localparam int P4  = 4;
  localparam int P8  = 8;
  localparam int P16 = 16;

  typedef enum logic [1:0] {
    CLEAN,
    CORR,
    UNC
  } err_class_e;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WAIT,
    CHK,
    WR,
    NXT
  } state_e;

endpackage

// File: rtl/hamming_syndrome_chk.sv
// Combinational SECDED check: syndrome, error class and single-bit repair.
// Bit 0 of the codeword is position 1; bit 15 is the overall parity (pos 16).
module hamming_syndrome_chk
  import hamming_pkg::*;
(
  input  logic [CW_W-1:0] cw,
  output logic [3:0]      syn,
  output err_class_e      cls,
  output logic [CW_W-1:0] fixed
);

  logic ovp;

  // Syndrome is the XOR of the indices of all set Hamming positions; then classify.
  always_comb begin
    syn = '0;
    for (int p = 1; p < P16; p++) begin
      if (cw[p-1]) syn ^= 4'(p);
    end
    ovp   = ^cw;
    fixed = cw;
    cls   = CLEAN;
    if (syn == 4'd0 && ovp) begin
      cls            = CORR;
      fixed[P16-1]   = ~cw[P16-1];
    end else if (syn != 4'd0 && ovp) begin
      cls              = CORR;
      fixed[syn-4'd1]  = ~cw[syn-4'd1];
    end else if (syn != 4'd0) begin
      cls = UNC;
    end
  end

endmodule

// File: rtl/hamming_scrub_ctrl.sv
// Background scrubber: reads every word, repairs single-bit errors in place,
// counts corrected/uncorrectable errors.
// Optional: HAMMING_SCRUB_AUTO_EN restarts a pass after AUTO_INTERVAL idle cycles.
module hamming_scrub_ctrl
  import hamming_pkg::*;
#(
  parameter int ADDR_W        = 8,
  parameter int DEPTH         = 256,
  parameter int CNT_W         = 16,
  parameter int AUTO_INTERVAL = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  output logic              busy,
  output logic              done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [CW_W-1:0]   mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [CW_W-1:0]   mem_rdata,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  unc_cnt,
  output logic [ADDR_W-1:0] last_unc_addr,
  input  logic              clr_cnt
);

  state_e            state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [CW_W-1:0]   rword;
  logic [3:0]        syn;
  err_class_e        cls;
  logic [CW_W-1:0]   fixed;
  logic              last_word;
  logic              go;
  logic              auto_go;
  logic              unused_syn;

  hamming_syndrome_chk u_chk (
    .cw    (rword),
    .syn   (syn),
    .cls   (cls),
    .fixed (fixed)
  );

  // The syndrome itself is only needed by the shared decoder datapath.
  assign unused_syn = ^syn;

`ifdef HAMMING_SCRUB_AUTO_EN
  logic [31:0] idle_cnt;

  // Count idle cycles; stop or leaving IDLE holds the count at zero.
  always_ff @(posedge clk) begin
    if (rst || state != IDLE || stop || auto_go) idle_cnt <= '0;
    else                                         idle_cnt <= idle_cnt + 32'd1;
  end

  assign auto_go = (state == IDLE) && !stop && (idle_cnt == 32'(AUTO_INTERVAL - 1));
`else
  // Keeps the interval parameter referenced when auto-restart is compiled out.
  localparam int unused_auto_interval = AUTO_INTERVAL;
  assign auto_go = 1'b0;
`endif

  assign go        = (start | auto_go) & ~stop;
  assign last_word = (addr == ADDR_W'(DEPTH - 1));
  assign busy      = (state != IDLE);
  assign mem_addr  = addr;
  // rword is frozen outside WAIT, so the write data is stable while awaiting grant.
  assign mem_wdata = fixed;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and memory-port/done decode.
  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (go) state_nxt = RD;
      RD: begin
        mem_req = 1'b1;
        if (mem_gnt) state_nxt = WAIT;
      end
      WAIT: if (mem_rvalid) state_nxt = CHK;
      CHK:  state_nxt = (cls == CORR) ? WR : NXT;
      WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_gnt) state_nxt = NXT;
      end
      NXT: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (last_word) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = RD;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address walk and read-word capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr  <= '0;
      rword <= '0;
    end else begin
      if (state == IDLE && go)                       addr <= '0;
      else if (state == NXT && !stop && !last_word)  addr <= addr + ADDR_W'(1);
      if (state == WAIT && mem_rvalid) rword <= mem_rdata;
    end
  end

  // Saturating error counters (clear wins) and last uncorrectable address.
  always_ff @(posedge clk) begin
    if (rst) begin
      corr_cnt      <= '0;
      unc_cnt       <= '0;
      last_unc_addr <= '0;
    end else begin
      if (clr_cnt) begin
        corr_cnt <= '0;
        unc_cnt  <= '0;
      end else if (state == CHK) begin
        if (cls == CORR && corr_cnt != '1) corr_cnt <= corr_cnt + CNT_W'(1);
        if (cls == UNC  && unc_cnt  != '1) unc_cnt  <= unc_cnt  + CNT_W'(1);
      end
      if (state == CHK && cls == UNC) last_unc_addr <= addr;
    end
  end

endmodule

// File: tb/tb_hamming_scrub_ctrl.sv
// Self-checking bench for hamming_scrub_ctrl with a 4-word memory model.
module tb_hamming_scrub_ctrl;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 3;
  localparam logic [CNT_W-1:0] SAT = '1;

  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, stop = 1'b0, clr_cnt = 1'b0;
  logic busy, done, mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr, last_unc_addr;
  logic [15:0] mem_wdata;
  logic mem_gnt = 1'b1, mem_rvalid = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic [CNT_W-1:0] corr_cnt, unc_cnt;

  hamming_scrub_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .AUTO_INTERVAL(1024)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .busy(busy), .done(done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .corr_cnt(corr_cnt), .unc_cnt(unc_cnt), .last_unc_addr(last_unc_addr), .clr_cnt(clr_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0;
  logic [ADDR_W-1:0] exp_last = '0;

  // ---------------- memory / arbiter model ----------------
  int cyc = 0, rd_cnt = 0, done_cnt = 0;
  logic [15:0] mem [DEPTH];
  logic [15:0] mem_init [DEPTH];
  int load_gen = 0, load_seen = 0;
  int lat_extra = 0, nxt_lat = 0, gnt_low_until = 0;
  bit lat_rand = 0, gnt_rand = 0;
  bit rd_pend = 0;
  int rd_lat = 0;
  logic [1:0] rd_addr = '0;
  logic [ADDR_W-1:0] wr_addr_q [$];
  logic [15:0] wr_data_q [$];

  always @(negedge clk) nxt_lat <= lat_rand ? int'($urandom_range(0, 3)) : lat_extra;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    mem_rvalid <= 1'b0;
    mem_gnt <= (cyc + 1 < gnt_low_until) ? 1'b0 : (gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1);
    if (load_gen != load_seen) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= mem_init[i];
      load_seen <= load_gen;
    end
    if (rst) begin
      rd_pend <= 1'b0;
    end else begin
      if (done) done_cnt <= done_cnt + 1;
      if (rd_pend) begin
        if (rd_lat == 0) begin
          mem_rvalid <= 1'b1;
          mem_rdata  <= mem[rd_addr];
          rd_pend    <= 1'b0;
        end else rd_lat <= rd_lat - 1;
      end
      if (mem_req && mem_gnt) begin
        if (mem_we) begin
          mem[mem_addr[1:0]] <= mem_wdata;
          wr_addr_q.push_back(mem_addr);
          wr_data_q.push_back(mem_wdata);
        end else begin
          rd_cnt <= rd_cnt + 1;
          if (nxt_lat == 0) begin
            mem_rvalid <= 1'b1;
            mem_rdata  <= mem[mem_addr[1:0]];
          end else begin
            rd_pend <= 1'b1;
            rd_lat  <= nxt_lat - 1;
            rd_addr <= mem_addr[1:0];
          end
        end
      end
    end
  end

  // ---------------- reference code model ----------------
  function automatic logic [15:0] encode(input logic [10:0] d);
    logic [15:0] c;
    int k;
    logic par;
    c = '0;
    k = 0;
    for (int p = 1; p <= 15; p++)
      if ((p & (p - 1)) != 0) begin c[p-1] = d[k]; k++; end
    for (int b = 0; b < 4; b++) begin
      par = 1'b0;
      for (int p = 1; p <= 15; p++)
        if (((p >> b) & 1) == 1 && p != (1 << b)) par ^= c[p-1];
      c[(1 << b) - 1] = par;
    end
    c[15] = ^c[14:0];
    return c;
  endfunction

  function automatic logic [10:0] extract(input logic [15:0] w);
    logic [10:0] d;
    int k;
    d = '0;
    k = 0;
    for (int p = 1; p <= 15; p++)
      if ((p & (p - 1)) != 0) begin d[k] = w[p-1]; k++; end
    return d;
  endfunction

  function automatic bit is_valid(input logic [15:0] w);
    return encode(extract(w)) == w;
  endfunction

  // 0 clean, 1 correctable (nearest codeword in fx), 2 uncorrectable.
  function automatic int classify(input logic [15:0] w, output logic [15:0] fx);
    fx = w;
    if (is_valid(w)) return 0;
    for (int i = 0; i < 16; i++)
      if (is_valid(w ^ (16'd1 << i))) begin fx = w ^ (16'd1 << i); return 1; end
    return 2;
  endfunction

  function automatic logic [15:0] rand_cw();
    return encode(11'($urandom));
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic load_mem();
    load_gen++;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(negedge clk) clr_cnt = 1'b1;
    @(negedge clk) clr_cnt = 1'b0;
  endtask

  task automatic run_pass();
    int n;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n = 0;
    while (busy && n < 600) begin @(negedge clk); n++; end
    n_cmp++;
    if (busy) begin n_fail++; $display("FAIL pass_timeout busy still %0b after %0d cycles", busy, n); end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({mem_req, mem_we, busy, done} !== 4'b0) begin
      n_fail++; $display("FAIL reset_ctrl got req/we/busy/done=%b want 0000", {mem_req, mem_we, busy, done});
    end
    n_cmp++;
    if (corr_cnt !== '0 || unc_cnt !== '0 || last_unc_addr !== '0) begin
      n_fail++; $display("FAIL reset_cnt got corr=%0d unc=%0d last=%0d want 0", corr_cnt, unc_cnt, last_unc_addr);
    end
    rst = 1'b0;
    exp_last = '0;
    @(negedge clk);
  endtask

  task automatic test_clean();
    int rd0, wr0, dn0;
    for (int i = 0; i < DEPTH; i++) mem_init[i] = rand_cw();
    load_mem();
    rd0 = rd_cnt; wr0 = wr_addr_q.size(); dn0 = done_cnt;
    run_pass();
    n_cmp++;
    if (rd_cnt - rd0 !== DEPTH) begin n_fail++; $display("FAIL clean_reads got %0d want %0d", rd_cnt - rd0, DEPTH); end
    n_cmp++;
    if (wr_addr_q.size() - wr0 !== 0) begin n_fail++; $display("FAIL clean_writes got %0d want 0", wr_addr_q.size() - wr0); end
    n_cmp++;
    if (done_cnt - dn0 !== 1) begin n_fail++; $display("FAIL clean_done got %0d want 1", done_cnt - dn0); end
    n_cmp++;
    if (corr_cnt !== '0 || unc_cnt !== '0) begin
      n_fail++; $display("FAIL clean_cnt got corr=%0d unc=%0d want 0", corr_cnt, unc_cnt);
    end
  endtask

  // Single flip at a Hamming position (pos 5) or at the overall parity (pos 16).
  task automatic test_single_bit(input int a, input int pos);
    int wr0;
    logic [15:0] orig;
    pulse_clr();
    for (int i = 0; i < DEPTH; i++) mem_init[i] = rand_cw();
    orig = mem_init[a];
    mem_init[a] = orig ^ (16'd1 << (pos - 1));
    load_mem();
    wr0 = wr_addr_q.size();
    run_pass();
    n_cmp++;
    if (wr_addr_q.size() - wr0 !== 1) begin
      n_fail++; $display("FAIL single_p%0d_writes got %0d want 1", pos, wr_addr_q.size() - wr0);
    end else begin
      n_cmp++;
      if (wr_addr_q[wr0] !== ADDR_W'(a) || wr_data_q[wr0] !== orig) begin
        n_fail++; $display("FAIL single_p%0d_wr got a=%0d d=%h want a=%0d d=%h", pos, wr_addr_q[wr0], wr_data_q[wr0], a, orig);
      end
    end
    n_cmp++;
    if (corr_cnt !== CNT_W'(1) || unc_cnt !== '0) begin
      n_fail++; $display("FAIL single_p%0d_cnt got corr=%0d unc=%0d want 1/0", pos, corr_cnt, unc_cnt);
    end
    n_cmp++;
    if (mem[a] !== orig) begin n_fail++; $display("FAIL single_p%0d_mem got %h want %h", pos, mem[a], orig); end
  endtask

  task automatic test_double();
    int wr0;
    pulse_clr();
    for (int i = 0; i < DEPTH; i++) mem_init[i] = rand_cw();
    mem_init[1] = mem_init[1] ^ (16'd1 << 2) ^ (16'd1 << 8);
    load_mem();
    wr0 = wr_addr_q.size();
    run_pass();
    exp_last = ADDR_W'(1);
    n_cmp++;
    if (wr_addr_q.size() - wr0 !== 0) begin n_fail++; $display("FAIL double_writes got %0d want 0", wr_addr_q.size() - wr0); end
    n_cmp++;
    if (unc_cnt !== CNT_W'(1) || corr_cnt !== '0) begin
      n_fail++; $display("FAIL double_cnt got corr=%0d unc=%0d want 0/1", corr_cnt, unc_cnt);
    end
    n_cmp++;
    if (last_unc_addr !== exp_last) begin n_fail++; $display("FAIL double_last got %0d want %0d", last_unc_addr, exp_last); end
  endtask

  task automatic test_clr();
    pulse_clr();
    n_cmp++;
    if (corr_cnt !== '0 || unc_cnt !== '0) begin
      n_fail++; $display("FAIL clr got corr=%0d unc=%0d want 0", corr_cnt, unc_cnt);
    end
    n_cmp++;
    if (last_unc_addr !== exp_last) begin n_fail++; $display("FAIL clr_last got %0d want %0d", last_unc_addr, exp_last); end
  endtask

  task automatic test_stall_stop();
    int rd0, dn0, n;
    logic [ADDR_W-1:0] a0;
    logic [15:0] d0;
    for (int i = 0; i < DEPTH; i++) mem_init[i] = rand_cw();
    load_mem();
    rd0 = rd_cnt; dn0 = done_cnt;
    @(negedge clk) begin gnt_low_until = cyc + 14; start = 1'b1; end
    @(negedge clk) start = 1'b0;
    a0 = mem_addr; d0 = mem_wdata;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if (!mem_req || mem_we || mem_addr !== a0 || a0 !== '0 || mem_wdata !== d0 || rd_cnt !== rd0) begin
        n_fail++; $display("FAIL stall_hold cyc%0d got req=%0b we=%0b a=%0d rd=%0d want 1/0/0/%0d", i, mem_req, mem_we, mem_addr, rd_cnt, rd0);
      end
    end
    stop = 1'b1;
    n = 0;
    while (busy && n < 100) begin @(negedge clk); n++; end
    stop = 1'b0;
    n_cmp++;
    if (busy) begin n_fail++; $display("FAIL stop_idle busy got %0b want 0", busy); end
    n_cmp++;
    if (rd_cnt - rd0 !== 1 || done_cnt - dn0 !== 0) begin
      n_fail++; $display("FAIL stop_finish got reads=%0d done=%0d want 1/0", rd_cnt - rd0, done_cnt - dn0);
    end
  endtask

  task automatic test_random();
    int wr0, dn0, nf, p1, p2, cls, ec, eu;
    logic [15:0] fx;
    logic [15:0] emem [DEPTH];
    logic [ADDR_W-1:0] ewa [$];
    logic [15:0] ewd [$];
    gnt_rand = 1; lat_rand = 1;
    for (int it = 0; it < 4; it++) begin
      pulse_clr();
      ewa.delete(); ewd.delete(); ec = 0; eu = 0;
      for (int a = 0; a < DEPTH; a++) begin
        mem_init[a] = rand_cw();
        nf = $urandom_range(0, 2);
        p1 = $urandom_range(0, 15);
        p2 = (p1 + 1 + $urandom_range(0, 14)) % 16;
        if (nf >= 1) mem_init[a] = mem_init[a] ^ (16'd1 << p1);
        if (nf == 2) mem_init[a] = mem_init[a] ^ (16'd1 << p2);
        cls = classify(mem_init[a], fx);
        emem[a] = fx;
        if (cls == 1) begin ewa.push_back(ADDR_W'(a)); ewd.push_back(fx); ec++; end
        if (cls == 2) begin eu++; exp_last = ADDR_W'(a); end
      end
      load_mem();
      wr0 = wr_addr_q.size(); dn0 = done_cnt;
      run_pass();
      n_cmp++;
      if (wr_addr_q.size() - wr0 !== ewa.size()) begin
        n_fail++; $display("FAIL rand%0d_writes got %0d want %0d", it, wr_addr_q.size() - wr0, ewa.size());
      end else begin
        for (int k = 0; k < ewa.size(); k++) begin
          n_cmp++;
          if (wr_addr_q[wr0+k] !== ewa[k] || wr_data_q[wr0+k] !== ewd[k]) begin
            n_fail++; $display("FAIL rand%0d_wr%0d got a=%0d d=%h want a=%0d d=%h", it, k, wr_addr_q[wr0+k], wr_data_q[wr0+k], ewa[k], ewd[k]);
          end
        end
      end
      n_cmp++;
      if (corr_cnt !== CNT_W'(ec) || unc_cnt !== CNT_W'(eu) || last_unc_addr !== exp_last) begin
        n_fail++; $display("FAIL rand%0d_cnt got corr=%0d unc=%0d last=%0d want %0d/%0d/%0d", it, corr_cnt, unc_cnt, last_unc_addr, ec, eu, exp_last);
      end
      n_cmp++;
      if (done_cnt - dn0 !== 1) begin n_fail++; $display("FAIL rand%0d_done got %0d want 1", it, done_cnt - dn0); end
      for (int a = 0; a < DEPTH; a++) begin
        n_cmp++;
        if (mem[a] !== emem[a]) begin n_fail++; $display("FAIL rand%0d_mem%0d got %h want %h", it, a, mem[a], emem[a]); end
      end
    end
    gnt_rand = 0; lat_rand = 0;
  endtask

  task automatic test_sat_reset();
    int ec, rd0, n;
    pulse_clr();
    ec = 0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int a = 0; a < DEPTH; a++) mem_init[a] = rand_cw() ^ (16'd1 << $urandom_range(0, 15));
      load_mem();
      run_pass();
      ec = (ec + DEPTH > int'(SAT)) ? int'(SAT) : ec + DEPTH;
      n_cmp++;
      if (corr_cnt !== CNT_W'(ec)) begin n_fail++; $display("FAIL sat_pass%0d got %0d want %0d", pass, corr_cnt, ec); end
    end
    for (int a = 0; a < DEPTH; a++) mem_init[a] = rand_cw() ^ 16'h0001;
    load_mem();
    lat_extra = 6;
    rd0 = rd_cnt;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n = 0;
    while (rd_cnt == rd0 && n < 50) begin @(negedge clk); n++; end
    n_cmp++;
    if (rd_cnt == rd0) begin n_fail++; $display("FAIL sat_read_wait got reads=%0d want >%0d", rd_cnt, rd0); end
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    exp_last = '0;
    n_cmp++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_ctrl got req=%0b busy=%0b done=%0b want 0", mem_req, busy, done);
    end
    n_cmp++;
    if (corr_cnt !== '0 || unc_cnt !== '0 || last_unc_addr !== exp_last) begin
      n_fail++; $display("FAIL rst_mid_cnt got corr=%0d unc=%0d last=%0d want 0", corr_cnt, unc_cnt, last_unc_addr);
    end
    rst = 1'b0;
    lat_extra = 0;
    repeat (10) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || mem_req !== 1'b0) begin
      n_fail++; $display("FAIL rst_after got busy=%0b req=%0b want 0", busy, mem_req);
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_single_bit(2, 5);
    test_double();
    test_single_bit(0, 16);
    test_clr();
    test_stall_stop();
    test_random();
    test_sat_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
